// File: rtl/gray_sync_decoder.sv
// Gray-count synchronizer and decoder: brings a foreign-domain gray count into clk_i,
// converts it to binary and reports forward distance. Optional step checker: GRAY_SYNC_DECODER_ERRCHK_EN.
module gray_sync_decoder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [WIDTH-1:0] gray_i,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] bin_o,
   output logic [WIDTH-1:0] delta_o,
   output logic             adv_o,
   output logic             err_o,
   output logic             err_sticky_o
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("gray_sync_decoder: SYNC_STAGES must be 2..4");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] gray_sync;
   logic [WIDTH-1:0] bin_d, bin_q;
   logic [WIDTH-1:0] delta_d, delta_q;
   logic             adv_d, adv_q;
   logic [WIDTH-1:0] dec_bin;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign gray_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      dec_bin = '0;
      dec_bin[WIDTH-1] = gray_sync[WIDTH-1];
      for (int k = WIDTH-2; k >= 0; k--) dec_bin[k] = dec_bin[k+1] ^ gray_sync[k];
   end

   // Steps missed while disabled accumulate naturally: distance is always against the held bin_q.
   always_comb begin
      bin_d   = bin_q;
      delta_d = delta_q;
      adv_d   = 1'b0;
      if (en_i) begin
         bin_d   = dec_bin;
         delta_d = dec_bin - bin_q;
         adv_d   = (dec_bin != bin_q);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bin_q   <= '0;
         delta_q <= '0;
         adv_q   <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         delta_q <= delta_d;
         adv_q   <= adv_d;
      end
   end

   assign bin_o   = bin_q;
   assign delta_o = delta_q;
   assign adv_o   = adv_q;

`ifdef GRAY_SYNC_DECODER_ERRCHK_EN
   logic [WIDTH-1:0] prev_gray_q;
   logic [WIDTH-1:0] gray_diff;
   logic             err_d, err_q;
   logic             sticky_d, sticky_q;

   // More than one bit set <=> clearing the lowest set bit leaves something behind.
   assign gray_diff = gray_sync ^ prev_gray_q;
   assign err_d     = ((gray_diff & (gray_diff - 1'b1)) != '0);
   assign sticky_d  = err_q | (sticky_q & ~clr_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prev_gray_q <= '0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         prev_gray_q <= gray_sync;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
      end
   end

   assign err_o        = err_q;
   assign err_sticky_o = sticky_q;
`else
   logic unused_clr;
   assign unused_clr   = clr_i;
   assign err_o        = 1'b0;
   assign err_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=8, SYNC_STAGES=2); error expectations
// follow whether GRAY_SYNC_DECODER_ERRCHK_EN is defined for the build.
module tb_gray_sync_decoder;
   localparam int WIDTH = 8;

`ifdef GRAY_SYNC_DECODER_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic             clk_sys = 1'b0;
   logic             rstn    = 1'b0;
   logic [WIDTH-1:0] gray    = '0;
   logic             en      = 1'b1;
   logic             clr     = 1'b0;
   logic [WIDTH-1:0] bin, delta;
   logic             adv, err, err_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   gray_sync_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) u_dut (
      .clk_i        (clk_sys),
      .rstn_i       (rstn),
      .gray_i       (gray),
      .en_i         (en),
      .clr_i        (clr),
      .bin_o        (bin),
      .delta_o      (delta),
      .adv_o        (adv),
      .err_o        (err),
      .err_sticky_o (err_sticky)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic step(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] exp_prev,
                       input logic [WIDTH-1:0] exp_bin, input logic [WIDTH-1:0] exp_delta,
                       input string tag);
      gray = g;
      tick(2);
      chk({tag, "_bin_early"}, bin, exp_prev);
      tick(1);
      chk({tag, "_bin"}, bin, exp_bin);
      chk({tag, "_delta"}, delta, exp_delta);
      chk({tag, "_adv"}, adv, 1);
      tick(1);
      chk({tag, "_adv_after"}, adv, 0);
      chk({tag, "_delta_after"}, delta, 0);
   endtask

   initial begin
      #2;
      chk("rst_bin", bin, 0);
      chk("rst_delta", delta, 0);
      chk("rst_adv", adv, 0);
      chk("rst_err", err, 0);
      chk("rst_sticky", err_sticky, 0);
      tick(2);
      rstn = 1'b1;
      tick(3);
      chk("idle_bin", bin, 0);
      chk("idle_adv", adv, 0);

      // Incrementing walk, one step every 4 cycles
      step(8'h01, 8'd0, 8'd1, 8'd1, "inc1");
      step(8'h03, 8'd1, 8'd2, 8'd1, "inc2");
      step(8'h02, 8'd2, 8'd3, 8'd1, "inc3");

      // Jump to top of range, then wrap to zero
      step(8'h80, 8'd3, 8'd255, 8'd252, "top");
      step(8'h00, 8'd255, 8'd0, 8'd1, "wrap");

      // Steps accumulated while disabled
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: gray = 8'h00;
            1: gray = 8'h01;
            2: gray = 8'h03;
            3: gray = 8'h02;
            default: gray = 8'h06;
         endcase
         tick(4);
         chk($sformatf("hold%0d_adv", i), adv, 0);
         chk($sformatf("hold%0d_bin", i), bin, 0);
      end
      chk("hold_delta", delta, 0);
      en = 1'b1;
      tick(1);
      chk("accum_bin", bin, 4);
      chk("accum_delta", delta, 4);
      chk("accum_adv", adv, 1);
      tick(1);
      chk("accum_adv_after", adv, 0);

      // Return to zero by single-bit steps, then clear any earlier sticky error
      gray = 8'h04;
      tick(4);
      gray = 8'h00;
      tick(4);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      chk("pre_err_sticky", err_sticky, 0);
      chk("pre_err", err, 0);

      // Illegal two-bit gray jump
      gray = 8'h05;
      tick(3);
      chk("jump_bin", bin, 6);
      chk("jump_err", err, ERRCHK ? 1 : 0);
      tick(1);
      chk("jump_err_pulse", err, 0);
      chk("jump_sticky", err_sticky, ERRCHK ? 1 : 0);
      tick(3);
      chk("jump_sticky_hold", err_sticky, ERRCHK ? 1 : 0);
      chk("jump_err_quiet", err, 0);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("clr_sticky", err_sticky, 0);

      // Asynchronous reset mid-operation
      gray = 8'h2C;
      tick(3);
      chk("pre_rst_bin", bin, 8'h37);
      @(posedge clk_sys);
      #2;
      rstn = 1'b0;
      gray = 8'h02;
      #1;
      chk("arst_bin", bin, 0);
      chk("arst_delta", delta, 0);
      chk("arst_adv", adv, 0);
      chk("arst_err", err, 0);
      chk("arst_sticky", err_sticky, 0);
      #1;
      rstn = 1'b1;
      tick(1);
      chk("post_rst_bin1", bin, 0);
      tick(1);
      chk("post_rst_bin2", bin, 0);
      tick(1);
      chk("post_rst_bin3", bin, 3);
      chk("post_rst_delta", delta, 3);
      chk("post_rst_adv", adv, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
